// File: rtl/axi_burst_pkg.sv
// rtl/axi_burst_pkg.sv - AXI4 write constants and FSM state types for the burst generator
// Purpose: shared encodings used by the master (design1_wrapper) and the memory slave.
// Ports:   none (package).
package axi_burst_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Master: IDLE -> AW -> (W <-> WNEXT)* -> B -> IDLE
    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        WNEXT,
        B
    } mst_state_t;

    // Slave: address phase, data phase, response phase
    typedef enum logic [1:0] {
        S_ADDR,
        S_DATA,
        S_RESP
    } slv_state_t;

    // One pixel per beat occupies the low 32 bits only.
    function automatic logic [7:0] wstrb_for(input logic one_pixel);
        return one_pixel ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/axi_burst_if.sv
// rtl/axi_burst_if.sv - user command/data port of the burst-write generator
// Purpose: groups the user-side command and per-beat data handshake.
// Ports:   user_addr_in, user_burst_len_in, user_data_in, user_pixels_1_2, user_start (user -> block);
//          user_free, user_stall_data, user_status (block -> user).
//          modport master = user side, modport slave = generator side.
interface axi_burst_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] user_addr_in;
    logic [3:0]        user_burst_len_in;
    logic [DATA_W-1:0] user_data_in;
    logic              user_pixels_1_2;
    logic              user_start;
    logic              user_free;
    logic              user_stall_data;
    logic [1:0]        user_status;

    modport master (
        output user_addr_in, user_burst_len_in, user_data_in, user_pixels_1_2, user_start,
        input  user_free, user_stall_data, user_status
    );

    modport slave (
        input  user_addr_in, user_burst_len_in, user_data_in, user_pixels_1_2, user_start,
        output user_free, user_stall_data, user_status
    );
endinterface

// File: rtl/axi_wr_mem_slave.sv
// rtl/axi_wr_mem_slave.sv - AXI4 write-only slave backed by a byte-strobed word memory
// Purpose: accepts one INCR burst at a time, writes MEM_DEPTH x DATA_W memory at
//          MEM_BASE, answers SLVERR (and writes nothing) for bursts outside the window.
// Ports:   aclk, aresetn (sync, active-high);
//          AW: awvalid/awready/awaddr/awlen/awsize/awburst;
//          W:  wvalid/wready/wdata/wstrb/wlast;
//          B:  bvalid/bready/bresp.
module axi_wr_mem_slave
    import axi_burst_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h1000_0000,
    parameter int                MEM_DEPTH = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp
);

    localparam int              STRB_W    = DATA_W / 8;
    localparam int              IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(MEM_DEPTH * STRB_W);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    slv_state_t        state, state_n;
    logic [IDX_W-1:0]  widx;
    logic [1:0]        bresp_r;

    // One extra bit so an address below the window shows up as a borrow,
    // and a burst running off the top of the window cannot wrap.
    logic [ADDR_W:0]   off;
    logic [ADDR_W:0]   burst_bytes;
    logic [ADDR_W:0]   end_off;
    logic              addr_ok;

    always_comb begin
        off         = {1'b0, awaddr} - {1'b0, MEM_BASE};
        burst_bytes = ({{(ADDR_W-3){1'b0}}, awlen} + (ADDR_W+1)'(1)) << 3;
        end_off     = off + burst_bytes;
        addr_ok     = !off[ADDR_W] && (off[2:0] == 3'b000) && (end_off <= WIN_BYTES)
                      && (awsize == SIZE_8B) && (awburst == BURST_INCR);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_ADDR:  if (awvalid)          state_n = S_DATA;
            S_DATA:  if (wvalid && wlast)  state_n = S_RESP;
            S_RESP:  if (bready)           state_n = S_ADDR;
            default:                       state_n = S_ADDR;
        endcase
    end

    assign awready = (state == S_ADDR);
    assign wready  = (state == S_DATA);
    assign bvalid  = (state == S_RESP);
    assign bresp   = bresp_r;

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state   <= S_ADDR;
            widx    <= '0;
            bresp_r <= RESP_OKAY;
        end else begin
            state <= state_n;
            if (awvalid && awready) begin
                widx    <= off[IDX_W+2:3];
                bresp_r <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (wvalid && wready) begin
                widx <= widx + IDX_W'(1);
            end
        end
    end

    // The response code latched at AW doubles as the write enable for the burst.
    always_ff @(posedge aclk) begin
        if (!aresetn && wvalid && wready && (bresp_r == RESP_OKAY)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/design1_wrapper.sv
// rtl/design1_wrapper.sv - AXI4 burst-write generator with user command/data port and on-chip slave
// Purpose: takes {addr, len, pixel mode} plus per-beat data from the user port, issues one
//          INCR write burst on an internal AXI4 write bus ending in axi_wr_mem_slave, and
//          reports the BRESP on user_status.
// Ports:   aclk     - sole clock (posedge)
//          aresetn  - synchronous reset, active-high
//          aclk_out - combinational copy of aclk for user logic
//          usr      - axi_burst_if.slave user command/data port
module design1_wrapper
    import axi_burst_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h1000_0000,
    parameter int                MEM_DEPTH = 256
) (
    input  logic      aclk,
    input  logic      aresetn,
    output logic      aclk_out,
    axi_burst_if.slave usr
);

    // Internal AXI4 write bus
    logic                awvalid, awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                wvalid, wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                bvalid, bready;
    logic [1:0]          bresp;

    mst_state_t        state, state_n;
    logic              free_r, free_n, free_q;
    logic              stall_r, stall_n;
    logic [1:0]        status_r, status_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [3:0]        len_r, len_n;
    logic [3:0]        cnt_r, cnt_n;
    logic              pix_r, pix_n;
    logic [DATA_W-1:0] beat_r, beat_n;
    logic              accept;

    assign aclk_out = aclk;

    // free_q forces one idle cycle after free rises before a held start is taken,
    // giving the user time to present the next command.
    assign accept = usr.user_start && free_r && free_q;

    always_comb begin
        state_n  = state;
        free_n   = free_r;
        stall_n  = stall_r;
        status_n = status_r;
        addr_n   = addr_r;
        len_n    = len_r;
        cnt_n    = cnt_r;
        pix_n    = pix_r;
        beat_n   = beat_r;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    addr_n  = usr.user_addr_in;
                    len_n   = usr.user_burst_len_in;
                    pix_n   = usr.user_pixels_1_2;
                    beat_n  = usr.user_data_in;
                    cnt_n   = 4'd0;
                    free_n  = 1'b0;
                    stall_n = 1'b1;
                    state_n = AW;
                end
            end
            AW: begin
                if (awready) state_n = W;
            end
            W: begin
                if (wready) begin
                    // Every handshake drops stall; after the last one it stays low.
                    stall_n = 1'b0;
                    if (cnt_r == len_r) begin
                        state_n = B;
                    end else begin
                        cnt_n   = cnt_r + 4'd1;
                        state_n = WNEXT;
                    end
                end
            end
            WNEXT: begin
                beat_n  = usr.user_data_in;
                stall_n = 1'b1;
                state_n = W;
            end
            B: begin
                if (bvalid) begin
                    status_n = bresp;
                    free_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state    <= IDLE;
            free_r   <= 1'b1;
            free_q   <= 1'b0;
            stall_r  <= 1'b0;
            status_r <= RESP_OKAY;
            addr_r   <= '0;
            len_r    <= '0;
            cnt_r    <= '0;
            pix_r    <= 1'b0;
            beat_r   <= '0;
        end else begin
            state    <= state_n;
            free_r   <= free_n;
            free_q   <= free_r;
            stall_r  <= stall_n;
            status_r <= status_n;
            addr_r   <= addr_n;
            len_r    <= len_n;
            cnt_r    <= cnt_n;
            pix_r    <= pix_n;
            beat_r   <= beat_n;
        end
    end

    assign awvalid = (state == AW);
    assign awaddr  = addr_r;
    assign awlen   = len_r;
    assign awsize  = SIZE_8B;
    assign awburst = BURST_INCR;
    assign wvalid  = (state == W);
    assign wdata   = beat_r;
    assign wstrb   = wstrb_for(pix_r);
    assign wlast   = (cnt_r == len_r);
    assign bready  = (state == B);

    assign usr.user_free       = free_r;
    assign usr.user_stall_data = stall_r;
    assign usr.user_status     = status_r;

    axi_wr_mem_slave #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_BASE  (MEM_BASE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_slave (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp)
    );

endmodule

// File: tb/tb_design1_wrapper.sv
// tb/tb_design1_wrapper.sv - self-checking bench for design1_wrapper against a word-level memory model
module tb_design1_wrapper;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 256;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    logic aclk_out;

    axi_burst_if usr ();

    design1_wrapper dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .aclk_out (aclk_out),
        .usr      (usr)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference memory: word contents plus which bytes are known
    logic [63:0] mdl   [DEPTH];
    logic [7:0]  known [DEPTH];
    logic [63:0] cmd_data [$];

    // Current command, used by the bus monitor
    logic [31:0] cur_addr = '0;
    logic [3:0]  cur_len  = '0;
    logic        cur_pix  = 1'b0;
    int aw_cnt  = 0;
    int w_cnt   = 0;
    int beat_no = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            if (dut.awvalid && dut.awready) begin
                aw_cnt++;
                beat_no = 0;
                check_val("awaddr",  dut.awaddr,  cur_addr);
                check_val("awlen",   dut.awlen,   cur_len);
                check_val("awsize",  dut.awsize,  3'b011);
                check_val("awburst", dut.awburst, 2'b01);
            end
            if (dut.wvalid && dut.wready) begin
                w_cnt++;
                check_val("wstrb", dut.wstrb, cur_pix ? 8'h0F : 8'hFF);
                check_val("wlast", dut.wlast, (beat_no == int'(cur_len)));
                beat_no++;
            end
        end
    end

    task automatic check_word(input int i);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{known[i][b]}};
        check_val($sformatf("mem[%0d]", i), dut.u_slave.mem[i] & m, mdl[i] & m);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [3:0] l, input logic p, input int abort_at);
        int beats, idx, falls, aw0, w0, t;
        logic prev;
        bit ok;
        longint off;
        beats = int'(l) + 1;
        while (cmd_data.size() < beats) cmd_data.push_back({$urandom, $urandom});
        off = longint'(a) - longint'(BASE);
        ok  = (off >= 0) && (off + beats * 8 <= DEPTH * 8);

        t = 0;
        while (usr.user_free !== 1'b1 && t < 100) begin @(negedge aclk); t++; end
        if (t >= 100) check_val("wait_free", usr.user_free, 1'b1);

        aw0 = aw_cnt;
        w0  = w_cnt;
        cur_addr = a; cur_len = l; cur_pix = p;
        usr.user_addr_in      = a;
        usr.user_burst_len_in = l;
        usr.user_pixels_1_2   = p;
        usr.user_data_in      = cmd_data[0];
        usr.user_start        = 1'b1;
        idx = 1;
        falls = 0;

        t = 0;
        do begin @(negedge aclk); t++; end while (usr.user_free && t < 20);
        if (usr.user_free) begin
            check_val("accept", usr.user_free, 1'b0);
            cmd_data.delete();
            return;
        end

        prev = usr.user_stall_data;
        t = 0;
        while (!usr.user_free && t < 200) begin
            @(negedge aclk);
            t++;
            if (prev && !usr.user_stall_data) begin
                falls++;
                if (idx < beats) begin
                    usr.user_data_in = cmd_data[idx];
                    idx++;
                end
                if (falls == abort_at) begin
                    aresetn = 1'b1;
                    usr.user_start = 1'b0;
                    @(negedge aclk);
                    check_val("rst_free",   usr.user_free,       1'b1);
                    check_val("rst_stall",  usr.user_stall_data, 1'b0);
                    check_val("rst_awv",    dut.awvalid,         1'b0);
                    check_val("rst_wv",     dut.wvalid,          1'b0);
                    check_val("rst_bready", dut.bready,          1'b0);
                    aresetn = 1'b0;
                    if (ok) for (int b = 0; b < beats; b++) known[int'(off / 8) + b] = 8'h00;
                    cmd_data.delete();
                    return;
                end
            end
            prev = usr.user_stall_data;
        end
        if (t >= 200) check_val("burst_timeout", usr.user_free, 1'b1);

        if (ok) begin
            for (int b = 0; b < beats; b++) begin
                int i;
                i = int'(off / 8) + b;
                if (p) begin
                    mdl[i][31:0] = cmd_data[b][31:0];
                    known[i] = known[i] | 8'h0F;
                end else begin
                    mdl[i]   = cmd_data[b];
                    known[i] = 8'hFF;
                end
            end
        end
        check_val("status", usr.user_status, ok ? 2'b00 : 2'b10);
        check_val("stall_falls", falls, beats);
        check_val("aw_per_cmd", aw_cnt - aw0, 1);
        check_val("w_per_cmd", w_cnt - w0, beats);
        if (ok) for (int b = 0; b < beats; b++) check_word(int'(off / 8) + b);
        cmd_data.delete();
    endtask

    initial begin
        logic [63:0] v;
        int aw_s, w_s;
        for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = '0; end
        usr.user_addr_in = '0; usr.user_burst_len_in = '0; usr.user_data_in = '0;
        usr.user_pixels_1_2 = 1'b0; usr.user_start = 1'b0;

        repeat (3) @(negedge aclk);
        check_val("reset_free",   usr.user_free,       1'b1);
        check_val("reset_stall",  usr.user_stall_data, 1'b0);
        check_val("reset_status", usr.user_status,     2'b00);
        check_val("reset_awv",    dut.awvalid,         1'b0);
        check_val("reset_wv",     dut.wvalid,          1'b0);
        check_val("reset_bready", dut.bready,          1'b0);
        check_val("aclk_out_lo",  aclk_out,            1'b0);
        @(posedge aclk); #1;
        check_val("aclk_out_hi",  aclk_out,            1'b1);
        @(negedge aclk);
        aresetn = 1'b0;

        repeat (8) @(negedge aclk);
        check_val("no_start_no_aw", aw_cnt, 0);

        cmd_data.push_back(64'h0000_0000_F8F4_F2F1);
        run_cmd(BASE, 4'd0, 1'b1, -1);

        v = '0;
        for (int b = 0; b < 16; b++) begin
            v[b*4 +: 4] = 4'hA + 4'(b);
            cmd_data.push_back(v);
        end
        run_cmd(BASE + 32'h80, 4'd15, 1'b1, -1);

        cmd_data.push_back(64'hBADC_AFEE_DEAD_BEEF);
        run_cmd(BASE + 32'h200, 4'd0, 1'b0, -1);

        aw_s = aw_cnt;
        w_s  = w_cnt;
        for (int i = 0; i < 10; i++)
            run_cmd(BASE + 32'(8 * $urandom_range(0, 255 - i)), 4'(i), 1'($urandom % 2), -1);
        check_val("b2b_aw", aw_cnt - aw_s, 10);
        check_val("b2b_w",  w_cnt - w_s,  55);

        run_cmd(32'h2000_0000, 4'd3, 1'b0, -1);
        run_cmd(BASE + 32'h7F0, 4'd1, 1'b0, -1);
        run_cmd(BASE + 32'h7F0, 4'd3, 1'b0, -1);
        check_word(254);
        check_word(255);
        run_cmd(BASE - 32'h8, 4'd1, 1'b0, -1);

        run_cmd(BASE + 32'h600, 4'd15, 1'b0, 5);
        run_cmd(BASE + 32'h100, 4'd2, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            logic [3:0] l;
            logic [31:0] a;
            l = 4'($urandom % 16);
            if ($urandom % 4 != 0) a = BASE + 32'(8 * $urandom_range(0, 255 - int'(l)));
            else                   a = $urandom & 32'hFFFF_FFF8;
            run_cmd(a, l, 1'($urandom % 2), -1);
        end

        usr.user_start = 1'b0;
        repeat (4) @(negedge aclk);
        for (int i = 0; i < DEPTH; i++) if (known[i] != 8'h00) check_word(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
